vpu_mul_iter: RTL and testbench

VPU_MUL_ITER -- requirements
Module: vpu_mul_iter

---
 rtl/vpu_mul_pkg.sv | 26 ++
 rtl/vpu_mul_iter.sv | 142 ++++++++++++++
 tb/tb_vpu_mul_iter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/vpu_mul_pkg.sv
// Shared types for the iterative VPU multiplier: operation encoding and FSM states.
package vpu_mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

    // MUL takes the signed view; its low half is identical for either interpretation.
    function automatic logic op_a_signed(input mul_op_e op);
        return op != OP_MULHU;
    endfunction

    function automatic logic op_b_signed(input mul_op_e op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/vpu_mul_iter.sv
// Iterative sign-magnitude shift-add multiplier: one multiplier bit per cycle,
// product sign fixed up once at the end, selected half presented with valid/ready.
module vpu_mul_iter
    import vpu_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    mul_state_e       state_q, state_d;
    mul_op_e          op_q, op_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q, out_valid_q, busy_q;
    logic [WIDTH-1:0] result_q, result_d;

    mul_op_e          op_in;
    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    shifted;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, datapath and registered-output next values
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;

        op_in    = mul_op_e'(op);
        accept   = in_valid && in_ready_q;
        a_neg    = op_a_signed(op_in) && a[WIDTH-1];
        b_neg    = op_b_signed(op_in) && b[WIDTH-1];
        a_mag    = a_neg ? WIDTH'(~a + WIDTH'(1)) : a;
        b_mag    = b_neg ? WIDTH'(~b + WIDTH'(1)) : b;

        // Upper half accumulates, lower half holds the remaining multiplier bits.
        addend   = prod_q[0] ? mcand_q : '0;
        sum      = {1'b0, prod_q[PW-1:WIDTH]} + {1'b0, addend};
        shifted  = {sum, prod_q[WIDTH-1:1]};

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = op_in;
                    neg_d   = a_neg ^ b_neg;
                    mcand_d = a_mag;
                    cnt_d   = '0;
                    if ((a == '0) || (b == '0)) begin
                        prod_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        prod_d  = {WIDTH'(0), b_mag};
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = CW'(cnt_q + CW'(1));
                if (cnt_q == CW'(WIDTH - 1)) begin
                    prod_d  = neg_q ? PW'(~shifted + PW'(1)) : shifted;
                    state_d = ST_DONE;
                end else begin
                    prod_d  = shifted;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        result_d = '0;
        if (state_d == ST_DONE) begin
            result_d = (op_d == OP_MUL) ? prod_d[WIDTH-1:0] : prod_d[PW-1:WIDTH];
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_MUL;
            neg_q       <= 1'b0;
            mcand_q     <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            op_q        <= op_d;
            neg_q       <= neg_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
            result_q    <= result_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;

endmodule

// File: tb/tb_vpu_mul_iter.sv
// Scoreboard bench for vpu_mul_iter (WIDTH=32): directed vectors, back-pressure,
// operand toggling during BUSY, mid-operation reset and random operations.
module tb_vpu_mul_iter;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    int n_checks;
    int n_errors;
    logic [W-1:0] exp_q[$];

    vpu_mul_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // Reference product using the bench's own 64-bit arithmetic.
    function automatic logic [W-1:0] ref_mul(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [63:0] sx, sy, uys;
        logic [63:0] ux, uy, p;
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        ux  = {32'b0, x};
        uy  = {32'b0, y};
        uys = uy;
        case (o)
            2'b00:   p = sx * sy;
            2'b01:   p = sx * sy;
            2'b10:   p = sx * uys;
            default: p = ux * uy;
        endcase
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op_i, input logic [W-1:0] a_i,
                          input logic [W-1:0] b_i, input logic [W-1:0] exp_i,
                          input int hold, input bit toggle);
        int n;
        int lat;
        int exp_lat;
        logic [W-1:0] want;
        logic [W-1:0] held;
        exp_lat = ((a_i == '0) || (b_i == '0)) ? 1 : W + 1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1;
        op = op_i;
        a = a_i;
        b = b_i;
        @(posedge clk);
        exp_q.push_back(exp_i);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (toggle) begin
                a  = $urandom;
                b  = $urandom;
                op = 2'($urandom_range(0, 3));
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        if (!out_valid) begin
            check({tag, "_valid_timeout"}, 64'(out_valid), 64'd1);
            void'(exp_q.pop_front());
            return;
        end
        check({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_result"}, 64'(result), 64'(want));
        check({tag, "_busy_done"}, 64'(busy), 64'd1);
        check({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
        held = result;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_result"}, 64'(result), 64'(held));
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_post_result"}, 64'(result), 64'd0);
        check({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_post_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [1:0]   r_op;
        logic [W-1:0] r_a, r_b;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a  = '0;
        b  = '0;
        op = 2'b00;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        run_op("mul_zero",   2'b00, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 0, 1'b0);
        run_op("mul_1x2",    2'b00, 32'h0000_0001, 32'h0000_0002, 32'h0000_0002, 0, 1'b0);
        run_op("mul_m1x2",   2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 0, 1'b0);
        run_op("mulh_m1x2",  2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("mulhsu_m1x2",2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("mulhu_m1x2", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 0, 1'b0);
        run_op("mul_m1xm2",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0002, 0, 1'b0);
        run_op("mulh_m1xm2", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0000, 0, 1'b0);
        run_op("mulhu_m1xm2",2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 1'b0);
        run_op("mulh_minsq", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 1'b0);
        run_op("mulhsu_min", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, ref_mul(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 0, 1'b0);
        run_op("mulh_bzero", 2'b01, 32'h8000_0001, 32'h0000_0000, 32'h0000_0000, 0, 1'b0);
        run_op("backpress",  2'b01, 32'h1234_5678, 32'h9ABC_DEF0, ref_mul(2'b01, 32'h1234_5678, 32'h9ABC_DEF0), 5, 1'b0);
        run_op("toggle",     2'b11, 32'hDEAD_BEEF, 32'h0BAD_F00D, ref_mul(2'b11, 32'hDEAD_BEEF, 32'h0BAD_F00D), 0, 1'b1);

        // Reset in the middle of BUSY aborts the operation.
        in_valid = 1'b1;
        op = 2'b00;
        a  = 32'h0000_0003;
        b  = 32'h0000_0005;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check("abort_no_valid", 64'(seen), 64'd0);
        check("abort_in_ready_after", 64'(in_ready), 64'd1);
        run_op("after_abort", 2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = $urandom;
            if (k == 3) r_a = 32'h8000_0000;
            if (k == 7) r_b = 32'h8000_0000;
            run_op("rand", r_op, r_a, r_b, ref_mul(r_op, r_a, r_b), k % 3, k[0]);
        end

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
